// File: rtl/avalon_st_pkg.sv
// avalon_st_pkg
//   Types and sizing helpers shared by the Avalon-ST packet source and the
//   receive-side packet blocks.
//   pkt_state_e : packet FSM states (GAP_S only reachable when the top is
//                 built with AVST_PKT_SRC_GAP_EN)
//   addr_w(n)   : bits needed to address an n-deep packet buffer
//   len_w(n)    : bits needed to hold a length in 0..n
package avalon_st_pkg;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        LOAD_S = 2'd1,
        SEND_S = 2'd2,
        GAP_S  = 2'd3
    } pkt_state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/avalon_st_pkt_buf.sv
// avalon_st_pkt_buf
//   Packet word store: one synchronous write port, one combinational read
//   port. Contents are deliberately not reset.
//   clk_i     : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : data at rd_addr_i (same cycle)
module avalon_st_pkt_buf
    import avalon_st_pkg::*;
#(
    parameter int DWIDTH      = 10,
    parameter int MAX_PKT_LEN = 16,
    parameter int AW          = addr_w(MAX_PKT_LEN)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/avalon_st_pkt_src.sv
// avalon_st_pkt_src
//   Buffers one packet written word-by-word, then streams it out as
//   Avalon-ST (readyLatency 0). A packet reaching MAX_PKT_LEN words without
//   a last marker is cut there and flagged on pkt_trunc_o.
//   Build option: define AVST_PKT_SRC_GAP_EN to insert one idle cycle
//   (GAP_S) after every packet before the next write is accepted.
//   clk_i, srst_i            : clock, async active-high reset
//   wr_data_i/valid_i/last_i : word write port
//   wr_ready_o               : write port can accept a word
//   src_*                    : Avalon-ST source (data, sop, eop, valid, ready)
//   pkt_trunc_o              : one-cycle pulse when a packet was truncated
module avalon_st_pkt_src
    import avalon_st_pkg::*;
#(
    parameter int DWIDTH      = 10,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              wr_valid_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              pkt_trunc_o
);

    localparam int AW = addr_w(MAX_PKT_LEN);
    localparam int LW = len_w(MAX_PKT_LEN);

    pkt_state_e        state_q, state_d;
    logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic              trunc_q, trunc_d;
    logic              wr_fire;
    logic              at_end;
    logic              is_eop;
    logic [DWIDTH-1:0] rd_data;

    avalon_st_pkt_buf #(
        .DWIDTH     (DWIDTH),
        .MAX_PKT_LEN(MAX_PKT_LEN),
        .AW         (AW)
    ) u_buf (
        .clk_i    (clk_i),
        .wr_en_i  (wr_fire),
        .wr_addr_i(wr_cnt_q),
        .wr_data_i(wr_data_i),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(rd_data)
    );

    // Ready is gated by reset directly so it reads 0 while reset is held.
    assign wr_ready_o = !srst_i && (state_q == IDLE_S || state_q == LOAD_S);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign at_end     = (wr_cnt_q == AW'(MAX_PKT_LEN - 1));
    assign is_eop     = (LW'(rd_ptr_q) == len_q - LW'(1));
    assign pkt_trunc_o = trunc_q;

    always_comb begin
        state_d             = state_q;
        wr_cnt_d            = wr_cnt_q;
        rd_ptr_d            = rd_ptr_q;
        len_d               = len_q;
        trunc_d             = 1'b0;
        src_valid_o         = 1'b0;
        src_data_o          = '0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;

        unique case (state_q)
            IDLE_S, LOAD_S: begin
                if (wr_fire) begin
                    // Word at the last buffer slot closes the packet even
                    // without a last marker; wr_cnt is held so it never wraps.
                    if (wr_last_i || at_end) begin
                        state_d = SEND_S;
                        len_d   = LW'(wr_cnt_q) + LW'(1);
                        trunc_d = !wr_last_i;
                    end else begin
                        state_d  = LOAD_S;
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            SEND_S: begin
                src_valid_o         = 1'b1;
                src_data_o          = rd_data;
                src_startofpacket_o = (rd_ptr_q == '0);
                src_endofpacket_o   = is_eop;
                if (src_ready_i) begin
                    if (is_eop) begin
                        rd_ptr_d = '0;
                        wr_cnt_d = '0;
`ifdef AVST_PKT_SRC_GAP_EN
                        state_d  = GAP_S;
`else
                        state_d  = IDLE_S;
`endif
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            GAP_S: begin
                state_d = IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q  <= IDLE_S;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            trunc_q  <= trunc_d;
        end
    end

endmodule

// File: doc/avalon_st_pkt_src.md
Name: avalon_st_pkt_src

Overview:
Avalon-ST packet transmitter, the source-side counterpart to the team's receive-then-sort packet blocks. It accepts one packet word-by-word over a simple write port into an internal buffer, then streams the stored packet out as Avalon-ST (valid/ready, sop/eop, readyLatency 0). It feeds sort/test blocks from a stimulus or CPU-side writer and serves as the reference packet driver in system benches.

Parameters:
DWIDTH, 10, data word width in bits
MAX_PKT_LEN, 16, max words per packet (>=2); buffer depth

Ports:
clk_i  in  1  clock; all logic on posedge
srst_i  in  1  reset, asynchronous, active-high
wr_data_i  in  DWIDTH  word to store
wr_valid_i  in  1  wr_data_i valid this cycle
wr_last_i  in  1  marks final word of packet (qualified by wr_valid_i)
wr_ready_o  out  1  block can accept a write word
src_data_o  out  DWIDTH  Avalon-ST data
src_startofpacket_o  out  1  first word of packet
src_endofpacket_o  out  1  last word of packet
src_valid_o  out  1  src_data_o valid
src_ready_i  in  1  downstream accepts word (readyLatency 0)
pkt_trunc_o  out  1  one-cycle pulse: packet cut at MAX_PKT_LEN

Behaviour:
- Reset (async assert, sync release by flop design): state=IDLE_S, counters=0; src_valid_o/sop/eop=0, src_data_o=0, wr_ready_o=0 while in reset, pkt_trunc_o=0. Buffer contents not reset.
- States: IDLE_S, LOAD_S, SEND_S (enum in package).
- IDLE_S: wr_ready_o=1. Write (wr_valid_i&&wr_ready_o) stores word at addr 0, wr_cnt<=1; if wr_last_i also set -> SEND_S with len=1, else -> LOAD_S.
- LOAD_S: wr_ready_o=1. Each write stores at wr_cnt, wr_cnt++. wr_last_i -> SEND_S, len=wr_cnt+1. Write landing at index MAX_PKT_LEN-1 without wr_last_i: treated as last, pkt_trunc_o pulses 1 cycle, -> SEND_S, len=MAX_PKT_LEN.
- SEND_S: wr_ready_o=0; writes ignored. src_valid_o=1; src_data_o=buf[rd_ptr]; sop=(rd_ptr==0); eop=(rd_ptr==len-1). Transfer = src_valid_o&&src_ready_i; on transfer rd_ptr++. Transfer with eop -> IDLE_S, rd_ptr<=0, wr_cnt<=0.
- Output data/sop/eop held stable while src_valid_o=1 and src_ready_i=0 (Avalon-ST rule).
- Single-word packet: sop and eop both 1 on same word.
- src_valid_o is 0 in IDLE_S and LOAD_S; sop/eop/data 0 outside SEND_S.
- Latency: first src_valid_o the cycle after the write carrying last; with src_ready_i held 1, packet of N words occupies N cycles in SEND_S. Next wr_ready_o=1 the cycle after eop transfer.
- Counter widths: addr $clog2(MAX_PKT_LEN); len $clog2(MAX_PKT_LEN+1); no wrap possible by construction.
- wr_valid_i with wr_ready_o=0 is dropped, no error.
- Reset mid-LOAD or mid-SEND: packet discarded, outputs drop to 0 immediately.

Optional Feature:
AVST_PKT_SRC_GAP_EN: defined -> extra state GAP_S entered after eop transfer, lasting exactly one cycle (src_valid_o=0, wr_ready_o=0), then IDLE_S; guarantees >=1 idle cycle between packets. Undefined -> SEND_S returns directly to IDLE_S, no GAP_S.

Decomposition:
- Package avalon_st_pkg: state enum type, addr/len width localparam functions, shared with receive-side blocks.
- One sub-module natural: avalon_st_pkt_buf (DWIDTH x MAX_PKT_LEN, 1 write port, async/comb read port); FSM and counters in top.

Test Plan:
- Write 4 words 0x001,0x002,0x003,0x004 (last on 4th), src_ready_i=1 -> sop with 0x001 cycle after last, eop with 0x004, 4 consecutive valid cycles, then wr_ready_o=1.
- Same 4-word packet, src_ready_i toggling 1,0,0,1,0,1,1 -> each word held stable while stalled, order 1..4 preserved, no duplication.
- Single word 0x3FF with last -> one valid cycle, sop=eop=1, data 0x3FF.
- 16 writes without last (MAX_PKT_LEN=16) -> pkt_trunc_o pulses once on 16th write, 16 words sent, eop on 16th.
- Assert srst_i mid-SEND after 2 of 5 words -> src_valid_o=0 same cycle; after release new 3-word packet sent correctly starting with sop.
- With AVST_PKT_SRC_GAP_EN: back-to-back packets -> exactly one cycle of wr_ready_o=0, src_valid_o=0 after eop; without it -> wr_ready_o=1 cycle after eop.
